axis_demux_1to4: RTL and testbench
==================================

Name: axis_demux_1to4

Overview:
Registered AXI-stream 1-to-4 demultiplexer/router. It is the inverse of the stream 4-to-1 mux. One input stream is steered to one of four output streams by `sel`. Each output has a one-entry output register with full-throughput handshake. When enabled, the routing decision is locked per packet using `last`. It sits in front of parallel processing lanes that a downstream 4-to-1 mux later recombines.

Parameters:
WIDTH, 16, data width in bits of the input and every output stream

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
sel  input  2  destination select (0..3)
data  input  WIDTH  input stream data
valid  input  1  input stream valid
ready  output  1  input stream ready (combinational)
last  input  1  input end-of-packet marker
data_k (k=0..3)  output  WIDTH  output stream k data (registered)
valid_k (k=0..3)  output  1  output stream k valid (registered)
ready_k (k=0..3)  input  1  output stream k ready
last_k (k=0..3)  output  1  output stream k end-of-packet (registered)

Behaviour:
- Single clock `clk`; reset is synchronous and active-low on `rst_n`, sampled on the rising edge.
- Reset values:
  - all data_k = 0, valid_k = 0, last_k = 0.
  - FSM = IDLE, sel_q = 0.
  - `ready` = 0 while rst_n = 0.
- Destination select: dest = sel in IDLE; dest = sel_q in BUSY.
- Input ready: ready = !valid_dest || ready_dest. This is combinational from the output register state and downstream ready.
- Input accept: valid && ready on a rising edge. On accept, output register dest loads data_dest <= data, last_dest <= last, valid_dest <= 1.
- Output drain: valid_k clears when valid_k && ready_k and register k is not reloaded in the same cycle.
- Simultaneous drain and load on the same output: the new beat replaces the old one, valid stays 1, and there is no bubble.
- Latency: exactly 1 cycle from input accept to valid_k asserted.
- Throughput: 1 beat per cycle sustained to any output whose ready_k is held 1.
- Non-target outputs hold their data, valid and last. They may drain independently in the same cycle the input loads another output.
- `ready` depends only on the dest register. A stalled non-target output never blocks the input.
- Data and last pass unmodified; no width conversion.
- FSM (only when the optional feature is compiled in):
  - IDLE: accept with last=0 → BUSY, sel_q <= sel. Accept with last=1 → stay IDLE (single-beat packet).
  - BUSY: accept with last=1 → IDLE. Otherwise stay BUSY. Changes on `sel` are ignored.
- Reset asserted mid-packet: FSM returns to IDLE, all valid_k drop, and buffered beats are discarded.
- AXI-stream rules:
  - valid_k never deasserts without a handshake, except by reset.
  - data_k and last_k are stable while valid_k && !ready_k.

Optional Feature:
Macro AXIS_DEMUX_PKT_LOCK_EN.
- Defined: the IDLE/BUSY FSM and sel_q are compiled in. Routing is locked to the `sel` value sampled on the first beat of each packet until the beat with last=1 is accepted.
- Undefined: no FSM, no sel_q. dest = sel on every beat, giving per-beat routing. `last` is still registered and forwarded to last_dest.
- All ports exist in both builds.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with valid=1, sel=2 → ready=0, all valid_k=0, data_k=0. After release, the first accept appears on valid_2 one cycle later.
2. Streaming: sel=1, data=0x0001..0x0008 back-to-back, ready_1=1 → valid_1 high for 8 consecutive cycles starting 1 cycle after the first accept. data_1 follows 0x0001..0x0008 in order, ready never drops, other valid_k stay 0.
3. Backpressure: sel=3, ready_3=0 → one beat 0xABCD is captured, then ready=0. Raise ready_3 for 1 cycle → 0xABCD is consumed and the next beat loads in the same cycle with no bubble.
4. Independent outputs: load 0x1111 into output 0 with ready_0=0, then sel=2 with ready_2=1 → ready=1 and beats flow to output 2 while valid_0/data_0=0x1111 hold unchanged.
5. Packet lock (macro defined): 4-beat packet with sel=1 on beat 0, sel switched to 3 on beats 1–3, last on beat 3 → all 4 beats appear on output 1 with last_1=1 on the 4th. The next packet with sel=3 goes to output 3.
6. Per-beat routing (macro undefined): same stimulus as test 5 → beat 0 appears on output 1 and beats 1–3 on output 3. Reset mid-packet (macro defined) → next beat routes by current sel.

Source files
------------

// File: rtl/axis_demux_1to4.sv
// Registered AXI-stream 1-to-4 router with a one-entry output register per lane.
// Define AXIS_DEMUX_PKT_LOCK_EN to lock the route per packet; otherwise every beat routes by sel.
module axis_demux_1to4 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    input  logic             last,
    output logic [WIDTH-1:0] data_0,
    output logic             valid_0,
    input  logic             ready_0,
    output logic             last_0,
    output logic [WIDTH-1:0] data_1,
    output logic             valid_1,
    input  logic             ready_1,
    output logic             last_1,
    output logic [WIDTH-1:0] data_2,
    output logic             valid_2,
    input  logic             ready_2,
    output logic             last_2,
    output logic [WIDTH-1:0] data_3,
    output logic             valid_3,
    input  logic             ready_3,
    output logic             last_3
);

    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [3:0]       last_q;
    logic [3:0]       last_d;
    logic [3:0]       rdy_s;
    logic [1:0]       dest_s;
    logic             ready_s;
    logic             accept_s;

    assign rdy_s = {ready_3, ready_2, ready_1, ready_0};

`ifdef AXIS_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] sel_q;

    // Packet-lock FSM: capture sel on the first beat, release after the last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
        end else if (accept_s) begin
            case (state_q)
                IDLE: begin
                    if (!last) begin
                        state_q <= BUSY;
                        sel_q   <= sel;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (last) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sel_q   <= 2'd0;
                end
            endcase
        end else begin
            state_q <= state_q;
            sel_q   <= sel_q;
        end
    end

    assign dest_s = (state_q == BUSY) ? sel_q : sel;
`else
    assign dest_s = sel;
`endif

    // Input handshake and next state of every output register (load wins over drain).
    always_comb begin
        ready_s  = rst_n && (!valid_q[dest_s] || rdy_s[dest_s]);
        accept_s = valid && ready_s;
        for (int k = 0; k < 4; k++) begin
            data_d[k]  = data_q[k];
            last_d[k]  = last_q[k];
            valid_d[k] = valid_q[k];
            if (accept_s && (dest_s == 2'(k))) begin
                data_d[k]  = data;
                last_d[k]  = last;
                valid_d[k] = 1'b1;
            end else if (valid_q[k] && rdy_s[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= {WIDTH{1'b0}};
            end
            valid_q <= 4'b0000;
            last_q  <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign ready   = ready_s;
    assign data_0  = data_q[0];
    assign data_1  = data_q[1];
    assign data_2  = data_q[2];
    assign data_3  = data_q[3];
    assign valid_0 = valid_q[0];
    assign valid_1 = valid_q[1];
    assign valid_2 = valid_q[2];
    assign valid_3 = valid_q[3];
    assign last_0  = last_q[0];
    assign last_1  = last_q[1];
    assign last_2  = last_q[2];
    assign last_3  = last_q[3];

endmodule

// File: tb/tb_axis_demux_1to4.sv
// Table-driven bench for axis_demux_1to4; expectations adapt to AXIS_DEMUX_PKT_LOCK_EN.
module tb_axis_demux_1to4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        last;
    logic [15:0] data_0, data_1, data_2, data_3;
    logic        valid_0, valid_1, valid_2, valid_3;
    logic        ready_0, ready_1, ready_2, ready_3;
    logic        last_0, last_1, last_2, last_3;

    int checks = 0;
    int errors = 0;

    axis_demux_1to4 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .data(data), .valid(valid),
        .ready(ready), .last(last),
        .data_0(data_0), .valid_0(valid_0), .ready_0(ready_0), .last_0(last_0),
        .data_1(data_1), .valid_1(valid_1), .ready_1(ready_1), .last_1(last_1),
        .data_2(data_2), .valid_2(valid_2), .ready_2(ready_2), .last_2(last_2),
        .data_3(data_3), .valid_3(valid_3), .ready_3(ready_3), .last_3(last_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [1:0]  sel;
        logic [15:0] data;
        logic        valid;
        logic        last;
        logic [3:0]  rdy;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [1:0]  port;
        logic [15:0] exp_data;
        logic        exp_last;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [1:0] s, input logic [15:0] d,
                                input logic v, input logic l, input logic [3:0] rdy,
                                input logic er, input logic [3:0] ev, input logic [1:0] p,
                                input logic [15:0] ed, input logic el, input string nm);
        vec_t x;
        x.rst_n = r; x.sel = s; x.data = d; x.valid = v; x.last = l; x.rdy = rdy;
        x.exp_ready = er; x.exp_valid = ev; x.port = p; x.exp_data = ed; x.exp_last = el;
        x.name = nm;
        vecs.push_back(x);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] port_data(input logic [1:0] p);
        case (p)
            2'd0:    return data_0;
            2'd1:    return data_1;
            2'd2:    return data_2;
            2'd3:    return data_3;
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic logic port_last(input logic [1:0] p);
        case (p)
            2'd0:    return last_0;
            2'd1:    return last_1;
            2'd2:    return last_2;
            2'd3:    return last_3;
            default: return 1'bx;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; sel = v.sel; data = v.data; valid = v.valid; last = v.last;
        {ready_3, ready_2, ready_1, ready_0} = v.rdy;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        check($sformatf("%s[%0d].ready", v.name, idx), {31'd0, ready}, {31'd0, v.exp_ready});
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d].valid", v.name, idx),
              {28'd0, valid_3, valid_2, valid_1, valid_0}, {28'd0, v.exp_valid});
        check($sformatf("%s[%0d].data_%0d", v.name, idx, v.port),
              {16'd0, port_data(v.port)}, {16'd0, v.exp_data});
        check($sformatf("%s[%0d].last_%0d", v.name, idx, v.port),
              {31'd0, port_last(v.port)}, {31'd0, v.exp_last});
    endtask

    initial begin
        rst_n = 1'b0; sel = 2'd2; data = 16'h9999; valid = 1'b1; last = 1'b1;
        {ready_3, ready_2, ready_1, ready_0} = 4'b1111;

        // Reset held 3 cycles with valid=1, sel=2
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst[%0d].ready", i), {31'd0, ready}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("rst[%0d].valid", i),
                  {28'd0, valid_3, valid_2, valid_1, valid_0}, 32'd0);
            check($sformatf("rst[%0d].data", i),
                  {16'd0, data_0 | data_1 | data_2 | data_3}, 32'd0);
            check($sformatf("rst[%0d].last", i),
                  {28'd0, last_3, last_2, last_1, last_0}, 32'd0);
        end

        // First accept after release lands on output 2
        add(1'b1, 2'd2, 16'h0042, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 16'h0042, 1'b1, "release");
        add(1'b1, 2'd2, 16'h0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 16'h0042, 1'b1, "release");

        // Streaming 8 beats to output 1
        for (int i = 1; i <= 8; i++) begin
            add(1'b1, 2'd1, 16'(i), 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 16'(i), 1'b1, "stream");
        end
        add(1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 16'h0008, 1'b1, "stream");

        // Backpressure on output 3, then drain+load with no bubble
        add(1'b1, 2'd3, 16'hABCD, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1000, 2'd3, 16'hABCD, 1'b1, "bp");
        add(1'b1, 2'd3, 16'h1234, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 2'd3, 16'hABCD, 1'b1, "bp");
        add(1'b1, 2'd3, 16'h1234, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 16'h1234, 1'b1, "bp");
        add(1'b1, 2'd3, 16'h0000, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000, 2'd3, 16'h1234, 1'b1, "bp");

        // Stalled output 0 does not block output 2
        add(1'b1, 2'd0, 16'h1111, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0001, 2'd0, 16'h1111, 1'b1, "indep");
        add(1'b1, 2'd2, 16'h2222, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0101, 2'd2, 16'h2222, 1'b1, "indep");
        add(1'b1, 2'd2, 16'h2223, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0101, 2'd0, 16'h1111, 1'b1, "indep");
        add(1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0000, 2'd2, 16'h2223, 1'b1, "indep");

        // 4-beat packet, sel switched after the first beat
        add(1'b1, 2'd1, 16'h5000, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 16'h5000, 1'b0, "pkt");
`ifdef AXIS_DEMUX_PKT_LOCK_EN
        add(1'b1, 2'd3, 16'h5001, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 16'h5001, 1'b0, "pkt");
        add(1'b1, 2'd3, 16'h5002, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 16'h5002, 1'b0, "pkt");
        add(1'b1, 2'd3, 16'h5003, 1'b1, 1'b1, 4'b1010, 1'b1, 4'b0010, 2'd1, 16'h5003, 1'b1, "pkt");
        add(1'b1, 2'd3, 16'h0000, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, 16'h5003, 1'b1, "pkt");
`else
        add(1'b1, 2'd3, 16'h5001, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 16'h5001, 1'b0, "pkt");
        add(1'b1, 2'd3, 16'h5002, 1'b1, 1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 16'h5002, 1'b0, "pkt");
        add(1'b1, 2'd3, 16'h5003, 1'b1, 1'b1, 4'b1010, 1'b1, 4'b1000, 2'd3, 16'h5003, 1'b1, "pkt");
        add(1'b1, 2'd3, 16'h0000, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b0000, 2'd3, 16'h5003, 1'b1, "pkt");
`endif
        add(1'b1, 2'd3, 16'h6000, 1'b1, 1'b1, 4'b1010, 1'b1, 4'b1000, 2'd3, 16'h6000, 1'b1, "pkt2");
        add(1'b1, 2'd3, 16'h0000, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b0000, 2'd3, 16'h6000, 1'b1, "pkt2");

        // Reset mid-packet discards buffered beat; next beat routes by current sel
        add(1'b1, 2'd1, 16'h7000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1, 16'h7000, 1'b0, "midrst");
        add(1'b0, 2'd1, 16'h7777, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 16'h0000, 1'b0, "midrst");
        add(1'b1, 2'd2, 16'h7001, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 16'h7001, 1'b1, "midrst");

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
